// File: rtl/bus_cycle_controller.sv
// Bus cycle controller: 8-state T-cycle sequencer arbitrating EX and IF requests.
// Optional fetch fairness via `BCC_FETCH_FAIRNESS_EN (starved IF wins every third contest).
module bus_cycle_controller #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_req,
    input  logic        ex_wr,
    input  logic [15:0] ex_addr,
    input  logic [15:0] ex_wdata,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        ex_gnt,
    output logic        if_gnt,
    output logic        ex_done,
    output logic        if_done,
    output logic [15:0] rd_data,
    output logic        bus_err,
    input  logic        ready,
    output logic [2:0]  t_state,
    output logic        busint,
    output logic        dtr_,
    output logic [15:0] addr_out,
    output logic [15:0] data_out,
    input  logic [15:0] data_in
);

    localparam int WW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    logic [2:0]    r_t;
    logic [2:0]    w_t_nxt;
    logic [WW-1:0] r_wait;
    logic          r_err;
    logic          r_own_ex;
    logic          r_busint;
    logic          r_dtr;
    logic [15:0]   r_addr;
    logic [15:0]   r_data;
    logic [15:0]   r_rd;
    logic          w_arb;
    logic          w_hold;
    logic          w_wait_full;
    logic          w_ex_win;
    logic          w_if_win;
`ifdef BCC_FETCH_FAIRNESS_EN
    logic [1:0]    r_starve;
`endif

    assign w_arb       = (r_t == 3'd7);
    assign w_wait_full = (r_wait == WW'(WAIT_MAX));
    assign w_hold      = (r_t == 3'd5) && r_busint && !ready && !w_wait_full;

    always_ff @(posedge clk) begin
        if (rst) r_t <= 3'd0;
        else     r_t <= w_t_nxt;
    end

    always_comb begin
        w_t_nxt = r_t + 3'd1;
        if (w_hold) w_t_nxt = 3'd5;
    end

    always_comb begin
        w_if_win = 1'b0;
        w_ex_win = 1'b0;
        if (w_arb) begin
`ifdef BCC_FETCH_FAIRNESS_EN
            w_if_win = if_req && (!ex_req || r_starve == 2'd2);
`else
            w_if_win = if_req && !ex_req;
`endif
            w_ex_win = ex_req && !w_if_win;
        end
    end

    always_comb begin
        ex_gnt  = w_ex_win;
        if_gnt  = w_if_win;
        ex_done = w_arb && r_busint && r_own_ex;
        if_done = w_arb && r_busint && !r_own_ex;
        bus_err = w_arb && r_busint && r_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait   <= '0;
            r_err    <= 1'b0;
            r_own_ex <= 1'b0;
            r_busint <= 1'b0;
            r_dtr    <= 1'b0;
            r_addr   <= 16'h0;
            r_data   <= 16'h0;
            r_rd     <= 16'h0;
        end else begin
            if (w_arb) begin
                r_busint <= w_ex_win || w_if_win;
                r_own_ex <= w_ex_win;
                r_dtr    <= w_ex_win && ex_wr;
                r_err    <= 1'b0;
                r_wait   <= '0;
                if (w_ex_win) begin
                    r_addr <= ex_addr;
                    r_data <= ex_wdata;
                end else if (w_if_win) begin
                    r_addr <= if_addr;
                end
            end
            if (r_t == 3'd5 && r_busint) begin
                if (w_hold) begin
                    r_wait <= r_wait + WW'(1);
                end else begin
                    // Leaving state 5 without ready means the wait budget ran out
                    if (!ready) r_err <= 1'b1;
                    if (!r_dtr) r_rd <= ready ? data_in : 16'hFFFF;
                end
            end
        end
    end

`ifdef BCC_FETCH_FAIRNESS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= 2'd0;
        end else if (w_arb) begin
            if (w_if_win)                r_starve <= 2'd0;
            else if (if_req && w_ex_win) r_starve <= r_starve + 2'd1;
        end
    end
`endif

    assign t_state  = r_t;
    assign busint   = r_busint;
    assign dtr_     = r_dtr;
    assign addr_out = r_addr;
    assign data_out = r_data;
    assign rd_data  = r_rd;

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Randomized bus-cycle-level bench for bus_cycle_controller.
// Model tracks whole bus cycles (winner, wait length, captured data), not RTL state.
module tb_bus_cycle_controller;

    localparam int WAIT_MAX = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_req, ex_wr, if_req, ready;
    logic [15:0] ex_addr, ex_wdata, if_addr, data_in;
    logic        ex_gnt, if_gnt, ex_done, if_done, bus_err, busint, dtr_;
    logic [15:0] rd_data, addr_out, data_out;
    logic [2:0]  t_state;

    int n_run = 0;
    int n_fail = 0;

    bit          m_busy, m_own_ex, m_err, m_wr;
    logic [15:0] m_rd;
    int          m_loss;
    bit          g_fix;
    logic [15:0] g_din;

    always #5 clk = ~clk;

    bus_cycle_controller #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst),
        .ex_req(ex_req), .ex_wr(ex_wr), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .if_req(if_req), .if_addr(if_addr),
        .ex_gnt(ex_gnt), .if_gnt(if_gnt), .ex_done(ex_done), .if_done(if_done),
        .rd_data(rd_data), .bus_err(bus_err), .ready(ready),
        .t_state(t_state), .busint(busint), .dtr_(dtr_),
        .addr_out(addr_out), .data_out(data_out), .data_in(data_in)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".ex_gnt"}, ex_gnt, 0);
        chk({tag, ".if_gnt"}, if_gnt, 0);
        chk({tag, ".ex_done"}, ex_done, 0);
        chk({tag, ".if_done"}, if_done, 0);
        chk({tag, ".bus_err"}, bus_err, 0);
    endtask

    // Leaves the bench 1ns after the edge that enters the first state 7.
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; ex_req = 0; if_req = 0; ex_wr = 0; ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.t_state", t_state, 0);
        chk("rst.busint", busint, 0);
        chk("rst.dtr_", dtr_, 0);
        chk("rst.addr_out", addr_out, 0);
        chk("rst.data_out", data_out, 0);
        chk("rst.rd_data", rd_data, 0);
        chk_quiet("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        m_busy = 0; m_own_ex = 0; m_err = 0; m_wr = 0; m_rd = 16'h0; m_loss = 0;
        for (int s = 0; s < 7; s++) begin
            if (s > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            chk("post_rst.t_state", t_state, s);
            chk("post_rst.busint", busint, 0);
            chk_quiet("post_rst");
        end
        @(posedge clk); #1;
    endtask

    // One bus cycle: arbitration in this state 7, then states 0..6 of the next cycle.
    task automatic run_cycle(input bit er, input bit ir, input bit wr,
                             input logic [15:0] ea, input logic [15:0] ed,
                             input logic [15:0] ia, input int nw);
        bit ew, iw;
        int reps;
        ex_req = er; if_req = ir; ex_wr = wr;
        ex_addr = ea; ex_wdata = ed; if_addr = ia;
        ready = 1'($urandom); data_in = 16'($urandom);
`ifdef BCC_FETCH_FAIRNESS_EN
        iw = ir && (!er || m_loss >= 2);
`else
        iw = ir && !er;
`endif
        ew = er && !iw;
        @(negedge clk);
        chk("t7.t_state", t_state, 7);
        chk("t7.ex_gnt", ex_gnt, ew);
        chk("t7.if_gnt", if_gnt, iw);
        chk("t7.ex_done", ex_done, m_busy && m_own_ex);
        chk("t7.if_done", if_done, m_busy && !m_own_ex);
        chk("t7.bus_err", bus_err, m_busy && m_err);
        if (m_busy) chk("t7.rd_data", rd_data, m_rd);
        if (iw) m_loss = 0;
        else if (ir && ew) m_loss++;
        m_busy = ew || iw; m_own_ex = ew; m_wr = ew && wr; m_err = 0;
        for (int s = 0; s < 7; s++) begin
            if (s == 5 && m_busy) reps = (nw > WAIT_MAX) ? WAIT_MAX + 1 : nw + 1;
            else reps = 1;
            for (int k = 0; k < reps; k++) begin
                @(posedge clk); #1;
                ex_req = 1'($urandom); if_req = 1'($urandom); ex_wr = 1'($urandom);
                data_in = g_fix ? g_din : 16'($urandom);
                ready = (s == 5 && m_busy) ? (k >= nw) : 1'($urandom);
                if (s == 5 && m_busy && k == reps - 1) begin
                    if (nw > WAIT_MAX) begin
                        m_err = 1;
                        if (!m_wr) m_rd = 16'hFFFF;
                    end else if (!m_wr) begin
                        m_rd = data_in;
                    end
                end
                @(negedge clk);
                chk("cyc.t_state", t_state, s);
                chk("cyc.busint", busint, m_busy);
                chk("cyc.dtr_", dtr_, m_wr);
                if (m_busy) chk("cyc.addr_out", addr_out, m_own_ex ? ea : ia);
                if (m_wr) chk("cyc.data_out", data_out, ed);
                chk_quiet("cyc");
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int nw;
        rst = 1'b1; ex_req = 0; if_req = 0; ex_wr = 0; ready = 0;
        ex_addr = 0; ex_wdata = 0; if_addr = 0; data_in = 0;
        g_fix = 0; g_din = 0;
        do_reset();
        run_cycle(0, 0, 0, 16'h0, 16'h0, 16'h0, 0);
        run_cycle(0, 0, 0, 16'h0, 16'h0, 16'h0, 0);
        g_fix = 1; g_din = 16'hBEEF;
        run_cycle(0, 1, 0, 16'h0, 16'h0, 16'h0100, 0);
        run_cycle(0, 0, 0, 16'h0, 16'h0, 16'h0, 0);
        g_fix = 0;
        run_cycle(1, 1, 1, 16'h2000, 16'h1234, 16'h0200, 0);
        run_cycle(0, 1, 0, 16'h0, 16'h0, 16'h0300, 3);
        run_cycle(0, 1, 0, 16'h0, 16'h0, 16'h0400, 20);
        run_cycle(1, 0, 1, 16'h5000, 16'h5555, 16'h0, 16);
        run_cycle(0, 1, 0, 16'h0, 16'h0, 16'h0500, 15);
        run_cycle(0, 0, 0, 16'h0, 16'h0, 16'h0, 0);
        for (int i = 0; i < 6; i++)
            run_cycle(1, 1, 0, 16'hA000 + 16'(i), 16'h0, 16'hB000 + 16'(i), 0);
        for (int i = 0; i < 150; i++) begin
            nw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(13, 20))
                                             : int'($urandom_range(0, 3));
            run_cycle(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
                      16'($urandom), 16'($urandom), nw);
        end
        ex_req = 1; if_req = 0; ex_wr = 1;
        repeat (3) begin @(posedge clk); #1; end
        do_reset();
        run_cycle(0, 1, 0, 16'h0, 16'h0, 16'h0600, 1);
        run_cycle(0, 0, 0, 16'h0, 16'h0, 16'h0, 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
